// File: rtl/encoder_r32i_pkg.sv
// Shared definitions for the RV32I instruction encoder: format codes,
// major opcode constants and the decoded-field bundle.
package encoder_r32i_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // Major opcodes, shared with the instruction decoder.
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } field_bundle_t;

    // Codes 6 and 7 have no instruction layout.
    function automatic logic fmt_legal(input logic [2:0] f);
        return f <= 3'(FMT_J);
    endfunction

endpackage

// File: rtl/encoder_r32i_imm_packer.sv
// Combinational immediate scatter for the RV32I encoder: places the Imm bits
// of each format into their instruction-word positions. With
// ENCODER_RANGECHECK_EN defined it also flags immediates that do not fit
// the format; otherwise extra bits are silently truncated.
module encoder_r32i_imm_packer
    import encoder_r32i_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        range_err
);

    // Scatter immediate bits into their per-format positions
    always_comb begin
        imm_bits = '0;
        case (fmt)
            FMT_I: imm_bits[31:20] = imm[11:0];
            FMT_S: begin
                imm_bits[31:25] = imm[11:5];
                imm_bits[11:7]  = imm[4:0];
            end
            FMT_B: begin
                imm_bits[31]    = imm[12];
                imm_bits[30:25] = imm[10:5];
                imm_bits[11:8]  = imm[4:1];
                imm_bits[7]     = imm[11];
            end
            FMT_U: imm_bits[31:12] = imm[31:12];
            FMT_J: begin
                imm_bits[31]    = imm[20];
                imm_bits[30:21] = imm[10:1];
                imm_bits[20]    = imm[11];
                imm_bits[19:12] = imm[19:12];
            end
            default: imm_bits = '0;
        endcase
    end

`ifdef ENCODER_RANGECHECK_EN
    // An immediate fits when every bit above the field equals its sign bit
    always_comb begin
        range_err = 1'b0;
        case (fmt)
            FMT_I, FMT_S: range_err = (imm[31:11] != {21{imm[11]}});
            FMT_B:        range_err = (imm[31:12] != {20{imm[12]}}) || imm[0];
            FMT_J:        range_err = (imm[31:20] != {12{imm[20]}}) || imm[0];
            FMT_U:        range_err = (imm[11:0] != 12'd0);
            default:      range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: rtl/encoder_r32i.sv
// RV32I instruction encoder / program writer. Field bundles enter S1 over a
// valid/ready stream; S2 holds the packed word and its word-aligned memory
// address. Bundles with an illegal format (or, with ENCODER_RANGECHECK_EN,
// an out-of-range immediate) are dropped at S1 and counted.
module encoder_r32i
    import encoder_r32i_pkg::*;
#(
    parameter int dataW = 32
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [2:0]       Fmt,
    input  logic [6:0]       Opcode,
    input  logic [2:0]       Funct3,
    input  logic [6:0]       Funct7,
    input  logic [4:0]       Rd,
    input  logic [4:0]       Rs1,
    input  logic [4:0]       Rs2,
    input  logic [dataW-1:0] Imm,
    input  logic             BaseLoad,
    input  logic [dataW-1:0] BaseAddr,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [dataW-1:0] InsWord,
    output logic [dataW-1:0] InsAddr,
    output logic             ErrSticky,
    output logic [7:0]       ErrCount
);

    logic             s1_valid;
    field_bundle_t    s1_data;
    logic             s2_valid;
    logic [dataW-1:0] ins_word;
    logic [dataW-1:0] ins_addr;
    logic [dataW-1:0] next_addr;
    logic             err_sticky;
    logic [7:0]       err_count;

    logic [31:0]      imm_bits;
    logic             range_err;
    logic             reject;
    logic             s2_ready;
    logic             s1_leave;
    logic             s1_ready;
    logic             xfer;
    logic [dataW-1:0] enc_word;
    logic [dataW-1:0] base_aligned;
    logic [dataW-1:0] xfer_addr;

    encoder_r32i_imm_packer u_imm_packer (
        .fmt       (s1_data.fmt),
        .imm       (s1_data.imm),
        .imm_bits  (imm_bits),
        .range_err (range_err)
    );

    // A rejected bundle leaves S1 without needing S2 space
    assign reject       = !fmt_legal(s1_data.fmt) || range_err;
    assign s2_ready     = !s2_valid || OutReady;
    assign s1_leave     = s1_valid && (reject || s2_ready);
    assign s1_ready     = !s1_valid || s1_leave;
    assign xfer         = s1_valid && !reject && s2_ready;
    assign base_aligned = BaseAddr & 32'hFFFF_FFFC;
    assign xfer_addr    = BaseLoad ? base_aligned : next_addr;

    assign InReady   = s1_ready;
    assign OutValid  = s2_valid;
    assign InsWord   = ins_word;
    assign InsAddr   = ins_addr;
    assign ErrSticky = err_sticky;
    assign ErrCount  = err_count;

    // Merge opcode and register fields with the placed immediate
    always_comb begin
        enc_word      = imm_bits;
        enc_word[6:0] = s1_data.opcode;
        case (s1_data.fmt)
            FMT_R: begin
                enc_word[31:25] = s1_data.funct7;
                enc_word[24:20] = s1_data.rs2;
                enc_word[19:15] = s1_data.rs1;
                enc_word[14:12] = s1_data.funct3;
                enc_word[11:7]  = s1_data.rd;
            end
            FMT_I: begin
                enc_word[19:15] = s1_data.rs1;
                enc_word[14:12] = s1_data.funct3;
                enc_word[11:7]  = s1_data.rd;
            end
            FMT_S, FMT_B: begin
                enc_word[24:20] = s1_data.rs2;
                enc_word[19:15] = s1_data.rs1;
                enc_word[14:12] = s1_data.funct3;
            end
            FMT_U, FMT_J: enc_word[11:7] = s1_data.rd;
            default: ;
        endcase
    end

    // S1: capture the incoming field bundle
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (s1_ready) begin
            s1_valid <= InValid;
            if (InValid) begin
                s1_data <= '{fmt: Fmt, opcode: Opcode, funct3: Funct3, funct7: Funct7,
                             rd: Rd, rs1: Rs1, rs2: Rs2, imm: Imm};
            end
        end
    end

    // S2: hold the encoded word and its address until accepted downstream
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            s2_valid <= 1'b0;
            ins_word <= '0;
            ins_addr <= '0;
        end else if (s2_ready) begin
            s2_valid <= xfer;
            if (xfer) begin
                ins_word <= enc_word;
                ins_addr <= xfer_addr;
            end
        end
    end

    // Address counter: advance on every good word, reload on BaseLoad
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            next_addr <= '0;
        end else if (xfer) begin
            next_addr <= xfer_addr + 32'd4;
        end else if (BaseLoad) begin
            next_addr <= base_aligned;
        end
    end

    // Error tracking for bundles dropped at S1; count saturates at 255
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (s1_valid && reject) begin
            err_sticky <= 1'b1;
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
